// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, word-addressed instruction memory with a load port,
// and the IF/ID pipeline register feeding Decode. Handles branch/jump redirects and stalls.
module fetch_stage #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic [25:0] jumpTarget,
  input  logic        imemWriteEnable,
  input  logic [31:0] imemWriteAddress,
  input  logic [31:0] imemWriteData,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic [31:0] pcPlusFour,
  output logic        instructionValid,
  output logic [31:0] fetchCount
);

  localparam int unsigned AddrW = $clog2(IMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  logic [AddrW-1:0] rd_idx;
  logic [AddrW-1:0] wr_idx;
  logic             rd_in_range;
  logic             wr_in_range;
  logic [31:0]      fetch_word;
  logic [31:0]      pc_plus4;

  // Byte-offset bits are ignored on both ports.
  logic unused_lsb;
  assign unused_lsb = ^{imemWriteAddress[1:0], branchTarget[1:0]};

  assign rd_idx      = pc_q[AddrW+1:2];
  assign wr_idx      = imemWriteAddress[AddrW+1:2];
  assign rd_in_range = (pc_q[31:AddrW+2] == '0);
  assign wr_in_range = (imemWriteAddress[31:AddrW+2] == '0);
  assign fetch_word  = rd_in_range ? imem[rd_idx] : 32'h0;
  assign pc_plus4    = pc_q + 32'd4;

  // Read is combinational off the pre-edge array, so a same-cycle write yields old data.
  always_ff @(posedge clock) begin
    if (imemWriteEnable && wr_in_range) begin
      imem[wr_idx] <= imemWriteData;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    count_d    = count_q;
    if (branchTaken) begin
      pc_d       = {branchTarget[31:2], 2'b00};
      instr_d    = 32'h0;
      pc_plus4_d = 32'h0;
      valid_d    = 1'b0;
    end else if (jump) begin
      pc_d       = {pc_q[31:28], jumpTarget, 2'b00};
      instr_d    = 32'h0;
      pc_plus4_d = 32'h0;
      valid_d    = 1'b0;
    end else if (!stall) begin
      pc_d       = pc_plus4;
      instr_d    = fetch_word;
      pc_plus4_d = pc_plus4;
      valid_d    = 1'b1;
      count_d    = count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      pc_plus4_q <= 32'h0;
      valid_q    <= 1'b0;
      count_q    <= 32'h0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
    end
  end

  assign pc               = pc_q;
  assign instruction      = instr_q;
  assign pcPlusFour       = pc_plus4_q;
  assign instructionValid = valid_q;
  assign fetchCount       = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: sequential fetch, stall, redirects,
// out-of-range fetch/write, write collision, PC wrap and asynchronous reset.
module tb_fetch_stage;

  logic        clock;
  logic        resetN;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [25:0] jumpTarget;
  logic        imemWriteEnable;
  logic [31:0] imemWriteAddress;
  logic [31:0] imemWriteData;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] pcPlusFour;
  logic        instructionValid;
  logic [31:0] fetchCount;

  int unsigned total;
  int unsigned passed;

  logic [31:0] words [4];

  fetch_stage #(
    .IMEM_DEPTH(64),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clock           (clock),
    .resetN          (resetN),
    .stall           (stall),
    .branchTaken     (branchTaken),
    .branchTarget    (branchTarget),
    .jump            (jump),
    .jumpTarget      (jumpTarget),
    .imemWriteEnable (imemWriteEnable),
    .imemWriteAddress(imemWriteAddress),
    .imemWriteData   (imemWriteData),
    .pc              (pc),
    .instruction     (instruction),
    .pcPlusFour      (pcPlusFour),
    .instructionValid(instructionValid),
    .fetchCount      (fetchCount)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Apply control for one edge, sample 1ns after it, then return controls to idle.
  task automatic cyc(input logic br, input logic [31:0] bt, input logic j,
                     input logic [25:0] jt, input logic st);
    branchTaken  = br;
    branchTarget = bt;
    jump         = j;
    jumpTarget   = jt;
    stall        = st;
    @(posedge clock);
    #1;
    branchTaken = 1'b0;
    jump        = 1'b0;
    stall       = 1'b0;
  endtask

  task automatic plain();
    cyc(1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
  endtask

  task automatic branch(input logic [31:0] bt);
    cyc(1'b1, bt, 1'b0, 26'h0, 1'b0);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    words[0] = 32'h0022_1800;
    words[1] = 32'h2001_0005;
    words[2] = 32'h8C22_0004;
    words[3] = 32'h0043_2820;
    stall = 1'b0; branchTaken = 1'b0; branchTarget = 32'h0; jump = 1'b0; jumpTarget = 26'h0;
    imemWriteEnable = 1'b0; imemWriteAddress = 32'h0; imemWriteData = 32'h0;
    resetN = 1'b1;
    #1 resetN = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_ppf", pcPlusFour, 32'h0);
    check("rst_valid", {31'h0, instructionValid}, 32'h0);
    check("rst_count", fetchCount, 32'h0);

    // Memory loads while reset is held.
    for (int i = 0; i < 4; i++) begin
      imemWriteEnable  = 1'b1;
      imemWriteAddress = 32'(i * 4);
      imemWriteData    = words[i];
      @(posedge clock);
      #1;
    end
    imemWriteEnable = 1'b0;
    check("rst_hold_count", fetchCount, 32'h0);
    resetN = 1'b1;

    plain();
    check("seq1_instr", instruction, 32'h0022_1800);
    check("seq1_ppf", pcPlusFour, 32'h4);
    plain();
    check("seq2_instr", instruction, 32'h2001_0005);
    check("seq2_ppf", pcPlusFour, 32'h8);
    plain();
    check("seq3_instr", instruction, 32'h8C22_0004);
    check("seq3_ppf", pcPlusFour, 32'hC);
    check("seq3_pc", pc, 32'hC);
    check("seq3_count", fetchCount, 32'd3);
    check("seq3_valid", {31'h0, instructionValid}, 32'h1);

    branch(32'h0);
    check("br0_pc", pc, 32'h0);
    check("br0_count", fetchCount, 32'd3);
    plain();
    check("pre_stall_instr", instruction, 32'h0022_1800);
    check("pre_stall_pc", pc, 32'h4);
    cyc(1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    check("stall1_pc", pc, 32'h4);
    cyc(1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    check("stall2_pc", pc, 32'h4);
    check("stall2_instr", instruction, 32'h0022_1800);
    check("stall2_count", fetchCount, 32'd4);
    plain();
    check("post_stall_instr", instruction, 32'h2001_0005);
    check("post_stall_pc", pc, 32'h8);
    check("post_stall_count", fetchCount, 32'd5);

    branch(32'h0000_0021);
    check("brmis_pc", pc, 32'h20);
    check("brmis_valid", {31'h0, instructionValid}, 32'h0);
    check("brmis_instr", instruction, 32'h0);
    check("brmis_ppf", pcPlusFour, 32'h0);
    check("brmis_count", fetchCount, 32'd5);

    branch(32'h10);
    cyc(1'b1, 32'h40, 1'b1, 26'h3, 1'b1);
    check("prio_br_pc", pc, 32'h40);
    check("prio_br_valid", {31'h0, instructionValid}, 32'h0);
    check("prio_br_instr", instruction, 32'h0);
    branch(32'h10);
    cyc(1'b0, 32'h40, 1'b1, 26'h3, 1'b1);
    check("prio_j_pc", pc, 32'hC);
    check("prio_j_valid", {31'h0, instructionValid}, 32'h0);
    check("prio_j_count", fetchCount, 32'd5);
    branch(32'h3000_0010);
    cyc(1'b0, 32'h0, 1'b1, 26'h3, 1'b0);
    check("j_hibits_pc", pc, 32'h3000_000C);

    branch(32'h100);
    plain();
    check("oor_instr", instruction, 32'h0);
    check("oor_valid", {31'h0, instructionValid}, 32'h1);
    check("oor_ppf", pcPlusFour, 32'h104);
    check("oor_count", fetchCount, 32'd6);

    branch(32'h4);
    imemWriteEnable  = 1'b1;
    imemWriteAddress = 32'h6;
    imemWriteData    = 32'hDEAD_BEEF;
    plain();
    imemWriteEnable = 1'b0;
    check("coll_old_instr", instruction, 32'h2001_0005);
    check("coll_count", fetchCount, 32'd7);
    branch(32'h4);
    plain();
    check("coll_new_instr", instruction, 32'hDEAD_BEEF);
    check("coll_new_count", fetchCount, 32'd8);

    imemWriteEnable  = 1'b1;
    imemWriteAddress = 32'h100;
    imemWriteData    = 32'hBADB_AD00;
    branch(32'h0);
    imemWriteEnable = 1'b0;
    plain();
    check("oor_write_dropped", instruction, 32'h0022_1800);
    check("oor_write_count", fetchCount, 32'd9);

    branch(32'hFFFF_FFFC);
    plain();
    check("wrap_ppf", pcPlusFour, 32'h0);
    check("wrap_pc", pc, 32'h0);
    check("wrap_instr", instruction, 32'h0);
    check("wrap_count", fetchCount, 32'd10);

    // Reset asserted mid-cycle, well away from any clock edge.
    #2 resetN = 1'b0;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_instr", instruction, 32'h0);
    check("arst_ppf", pcPlusFour, 32'h0);
    check("arst_valid", {31'h0, instructionValid}, 32'h0);
    check("arst_count", fetchCount, 32'h0);
    @(posedge clock);
    #1 resetN = 1'b1;
    plain();
    check("arst_rel_instr", instruction, 32'h0022_1800);
    check("arst_rel_count", fetchCount, 32'd1);
    check("arst_rel_valid", {31'h0, instructionValid}, 32'h1);
    check("arst_rel_pc", pc, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the Decode stage.
- Holds the program counter and a word-addressed instruction memory that is loaded through a write port.
- Drives the IF/ID pipeline register; its registered instruction output feeds Decode's instruction input.
- Handles branch and jump redirects, stalls, and flushes, and keeps a count of issued instructions for debug.

Parameters:
- IMEM_DEPTH, 64, number of 32-bit words in instruction memory (power of two, at least 4).
- RESET_PC, 32'h00000000, PC value loaded on reset (must be word-aligned).

Ports:
- clock  in  1  rising-edge clock.
- resetN  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and the IF/ID register.
- branchTaken  in  1  redirect the PC to branchTarget.
- branchTarget  in  32  branch destination byte address.
- jump  in  1  redirect the PC to the pseudo-direct jump target.
- jumpTarget  in  26  J-type instr_index field.
- imemWriteEnable  in  1  instruction-memory load strobe.
- imemWriteAddress  in  32  byte address of the word to load.
- imemWriteData  in  32  word to load.
- pc  out  32  current fetch address.
- instruction  out  32  IF/ID instruction; goes to Decode.
- pcPlusFour  out  32  IF/ID copy of (fetch PC + 4).
- instructionValid  out  1  IF/ID valid bit.
- fetchCount  out  32  number of valid instructions issued since reset.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (resetN); all registers are cleared immediately when resetN falls, regardless of clock.
- Reset values: pc=RESET_PC, instruction=32'h0 (NOP), pcPlusFour=0, instructionValid=0, fetchCount=0. Memory contents are not reset.
- Fetch read: combinational, word = imem[pc[log2(IMEM_DEPTH)+1:2]]. If pc[31:2] >= IMEM_DEPTH, the fetched word is 32'h0.
- Memory write: synchronous on the clock edge when imemWriteEnable=1, to index imemWriteAddress[log2(IMEM_DEPTH)+1:2].
  - Address bits [1:0] are ignored.
  - Out-of-range writes are dropped.
  - A write and a fetch of the same word in the same cycle: the fetch returns the old data; new data is visible the next cycle.
  - Writes are allowed during stall and during reset release.
- Normal cycle (no redirect, no stall), one-cycle latency PC to IF/ID:
  - instruction <= fetched word
  - pcPlusFour <= pc+4
  - instructionValid <= 1
  - pc <= pc+4
  - fetchCount <= fetchCount+1
- Redirect priority: branchTaken > jump > stall > sequential.
- branchTaken=1:
  - pc <= {branchTarget[31:2], 2'b00}; a misaligned target is silently aligned.
  - IF/ID is flushed: instruction <= 0, instructionValid <= 0, pcPlusFour <= 0.
  - fetchCount is unchanged.
- jump=1 (branchTaken=0):
  - pc <= {pc[31:28], jumpTarget, 2'b00}, using the current pc.
  - Same flush as a branch.
  - If branchTaken and jump are both asserted, the branch wins.
- Redirect during stall: the redirect wins; the PC updates and IF/ID is flushed.
- stall=1 with no redirect: pc, IF/ID, and fetchCount all hold.
- Wrap-around:
  - pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0).
  - fetchCount wraps modulo 2^32.
- Reset mid-operation: immediate return to reset values. The first valid instruction appears one clock edge after resetN rises.
- Arithmetic is unsigned 32-bit. No exceptions are raised.

Test Plan:
- Sequential fetch: load imem[0..2] = 32'h00221800, 32'h20010005, 32'h8C220004; release reset; 3 edges.
  - After each edge, instruction shows those words in order.
  - pcPlusFour = 4, 8, 12; pc = 12; fetchCount = 3; instructionValid = 1.
- Stall: stall=1 for 2 cycles after the first fetch.
  - pc stays 4; instruction stays 32'h00221800; fetchCount stays 1.
  - After stall drops, the next edge gives instruction = 32'h20010005.
- Branch flush: with pc=8, assert branchTaken with branchTarget=32'h00000021.
  - Next edge: pc = 32'h20, instructionValid = 0, instruction = 0, fetchCount unchanged.
- Branch vs jump vs stall: with pc=32'h10, assert branchTaken (target 0x40), jump (jumpTarget 26'h3), and stall together.
  - Next edge: pc = 32'h40 and IF/ID is flushed.
  - Repeat with branchTaken=0: pc = 32'h0000000C.
- Out-of-range and write collision:
  - pc=4*IMEM_DEPTH -> instruction=0 with valid=1.
  - Write 32'hDEADBEEF to the word currently being fetched -> IF/ID gets the old word; a re-fetch gets 32'hDEADBEEF.
- Async reset mid-run: drop resetN between clock edges.
  - Outputs go to reset values at once, without waiting for a clock edge.
  - After release, the first edge gives instruction = imem[0] and fetchCount = 1.
